// File: rtl/functional_unit_pipe.sv
// functional_unit_pipe: pipelined integer functional unit with a valid/ready handshake
// on both sides. Ops 0-10 and illegal opcodes complete in one cycle. MADD (opcode 11)
// takes two cycles and exists only when FUNCTIONAL_UNIT_MADD_EN is defined. In the default
// build there is no multiplier and no MUL state, and opcode 11 is handled as illegal.
module functional_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [4:0]       INST,
  input  logic             CI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Z,
  output logic [3:0]       FLAGS,
  output logic             ILLEGAL,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpAnd  = 5'd2;
  localparam logic [4:0] OpOr   = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpNot  = 5'd5;
  localparam logic [4:0] OpShl  = 5'd6;
  localparam logic [4:0] OpShr  = 5'd7;
  localparam logic [4:0] OpSra  = 5'd8;
  localparam logic [4:0] OpRol  = 5'd9;
  localparam logic [4:0] OpPass = 5'd10;
  localparam logic [4:0] OpMadd = 5'd11;

  logic [WIDTH-1:0] z_q;
  logic [3:0]       flags_q;
  logic             illegal_q;
  logic             valid_q;

  logic [SHW-1:0]   shamt;
  logic             out_free;
  logic             accept;

  // Single-cycle result for the operation currently presented on the inputs.
  logic [WIDTH-1:0]   res_z;
  logic               res_c;
  logic               res_v;
  logic               res_illegal;
  logic [3:0]         res_flags;
  logic [WIDTH:0]     sra_wide;
  logic [2*WIDTH-1:0] rol_wide;

  assign shamt    = B[SHW-1:0];
  assign out_free = !valid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  assign Z         = z_q;
  assign FLAGS     = flags_q;
  assign ILLEGAL   = illegal_q;
  assign OUT_VALID = valid_q;

  // Combinational datapath for ops that complete in one cycle, plus illegal decode.
  always_comb begin
    res_z       = '0;
    res_c       = 1'b0;
    res_v       = 1'b0;
    res_illegal = 1'b0;
    // Carry-out of a shift is the extra bit shifted beyond the word; a zero shift yields 0.
    sra_wide    = $signed({A, 1'b0}) >>> shamt;
    rol_wide    = {A, A} << shamt;
    case (INST)
      OpAdd: begin
        {res_c, res_z} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CI};
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (res_z[WIDTH-1] != A[WIDTH-1]);
      end
      OpSub: begin
        // Carry is the inverted borrow: set when A >= B unsigned.
        {res_c, res_z} = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (res_z[WIDTH-1] != A[WIDTH-1]);
      end
      OpAnd:  res_z = A & B;
      OpOr:   res_z = A | B;
      OpXor:  res_z = A ^ B;
      OpNot:  res_z = ~A;
      OpShl:  {res_c, res_z} = {1'b0, A} << shamt;
      OpShr:  {res_z, res_c} = {A, 1'b0} >> shamt;
      OpSra:  {res_z, res_c} = sra_wide;
      OpRol: begin
        res_z = rol_wide[2*WIDTH-1:WIDTH];
        // The bit rotated out of the top lands in bit 0.
        res_c = (shamt != '0) && res_z[0];
      end
      OpPass: res_z = A;
      default: res_illegal = 1'b1;
    endcase
    if (res_illegal) begin
      res_z = '0;
      res_c = 1'b0;
      res_v = 1'b0;
    end
  end

  assign res_flags = res_illegal ? 4'b0000
                                 : {res_z[WIDTH-1], (res_z == '0), res_c, res_v};

`ifdef FUNCTIONAL_UNIT_MADD_EN
  typedef enum logic {StIdle, StMul} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] product_q;
  logic [WIDTH-1:0] addend_q;
  logic [WIDTH-1:0] madd_z;
  logic             madd_c;
  logic             is_madd;

  assign is_madd  = (INST == OpMadd);
  assign IN_READY = RESET_N && (state_q == StIdle) && out_free;

  // Second MADD stage: low product plus addend.
  always_comb begin
    {madd_c, madd_z} = {1'b0, product_q} + {1'b0, addend_q};
  end

  // Control FSM with registered result, flags and handshake state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      z_q       <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
      product_q <= '0;
      addend_q  <= '0;
    end else begin
      // A consumed result drops unless a new one loads below on the same edge.
      if (OUT_READY) valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_madd) begin
              product_q <= A * B;
              addend_q  <= C;
              state_q   <= StMul;
            end else begin
              z_q       <= res_z;
              flags_q   <= res_flags;
              illegal_q <= res_illegal;
              valid_q   <= 1'b1;
            end
          end
        end
        StMul: begin
          // Hold product and addend until the output register can take the result.
          if (out_free) begin
            z_q       <= madd_z;
            flags_q   <= {madd_z[WIDTH-1], (madd_z == '0), madd_c, 1'b0};
            illegal_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  // C only feeds MADD, which is absent from this build.
  logic unused_c;
  assign unused_c = ^C;

  assign IN_READY = RESET_N && out_free;

  // Output register: every accepted operation, legal or not, completes in one cycle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q   <= 1'b0;
      z_q       <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      if (OUT_READY) valid_q <= 1'b0;
      if (accept) begin
        z_q       <= res_z;
        flags_q   <= res_flags;
        illegal_q <= res_illegal;
        valid_q   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_functional_unit_pipe.sv
// Testbench for functional_unit_pipe (WIDTH=32): directed corner cases and random ops
// checked against an arithmetic reference model. Tracks FUNCTIONAL_UNIT_MADD_EN.
module tb_functional_unit_pipe;

  localparam int unsigned W = 32;
`ifdef FUNCTIONAL_UNIT_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [W-1:0]  A = '0, B = '0, C = '0;
  logic [4:0]    INST = '0;
  logic          CI = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [W-1:0]  Z;
  logic [3:0]    FLAGS;
  logic          ILLEGAL;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;

  int compared = 0;
  int mismatched = 0;

  functional_unit_pipe #(.WIDTH(W)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .A(A), .B(B), .C(C), .INST(INST), .CI(CI),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Z(Z), .FLAGS(FLAGS), .ILLEGAL(ILLEGAL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model built from signed/unsigned integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [4:0] inst, input logic ci,
                       output logic [W-1:0] z, output logic [3:0] f, output logic ill);
    longint sa, sb, r;
    longint unsigned ua, ub, uc, p;
    int s;
    logic cy, ov, bit_out;
    logic [W-1:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    uc = longint'(c);
    s = int'(b[4:0]);
    z = '0; cy = 1'b0; ov = 1'b0; ill = 1'b0;
    case (inst)
      5'd0: begin
        r = sa + sb + longint'(ci);
        z = W'(ua + ub + longint'(ci));
        cy = (ua + ub + longint'(ci)) > 64'hFFFF_FFFF;
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      5'd1: begin
        r = sa - sb;
        z = W'(ua - ub);
        cy = (ua >= ub);
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      5'd2: z = a & b;
      5'd3: z = a | b;
      5'd4: z = a ^ b;
      5'd5: z = ~a;
      5'd6: begin z = a << s; cy = (s == 0) ? 1'b0 : a[W-s]; end
      5'd7: begin z = a >> s; cy = (s == 0) ? 1'b0 : a[s-1]; end
      5'd8: begin z = W'($signed(a) >>> s); cy = (s == 0) ? 1'b0 : a[s-1]; end
      5'd9: begin
        t = a;
        for (int k = 0; k < s; k++) begin
          bit_out = t[W-1];
          t = {t[W-2:0], bit_out};
          cy = bit_out;
        end
        z = t;
      end
      5'd10: z = a;
      5'd11: begin
        if (MaddEn) begin
          p = (ua * ub) & 64'hFFFF_FFFF;
          z = W'(p + uc);
          cy = (p + uc) > 64'hFFFF_FFFF;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    f = ill ? 4'b0000 : {z[W-1], (z == 0), cy, ov};
  endtask

  // Called just after a rising edge; returns just after the edge where the result shows.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [4:0] inst, input logic ci);
    logic [W-1:0] ez;
    logic [3:0] ef;
    logic ei;
    int n;
    model(a, b, c, inst, ci, ez, ef, ei);
    A = a; B = b; C = c; INST = inst; CI = ci; IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 10) begin
      @(posedge CLOCK); #1;
      n++;
    end
    if (!IN_READY) check({tag, "_ready_timeout"}, IN_READY, 1);
    @(posedge CLOCK); #1;
    IN_VALID = 1'b0;
    if (inst == 5'd11 && MaddEn) begin
      check({tag, "_mul_inready"}, IN_READY, 0);
      check({tag, "_mul_outvalid"}, OUT_VALID, 0);
      @(posedge CLOCK); #1;
    end
    check({tag, "_z"}, Z, ez);
    check({tag, "_flags"}, FLAGS, ef);
    check({tag, "_illegal"}, ILLEGAL, ei);
    check({tag, "_valid"}, OUT_VALID, 1);
  endtask

  initial begin
    logic [W-1:0] z1;

    // Reset state, sampled while reset is asserted.
    #2;
    check("rst_valid", OUT_VALID, 0);
    check("rst_z", Z, 0);
    check("rst_flags", FLAGS, 0);
    check("rst_illegal", ILLEGAL, 0);
    check("rst_inready", IN_READY, 0);
    #10 RESET_N = 1'b1;
    @(posedge CLOCK); #1;
    check("rel_inready", IN_READY, 1);

    // Directed corner cases.
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, '0, 5'd0, 1'b0);
    check("add_wrap_flags_lit", FLAGS, 4'b0110);
    do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, '0, 5'd1, 1'b0);
    check("sub_ovf_z_lit", Z, 32'h7FFF_FFFF);
    do_op("madd", 32'h0001_0000, 32'h0001_0000, 32'h0000_0005, 5'd11, 1'b0);
    check("madd_z_lit", Z, MaddEn ? 32'h0000_0005 : 32'h0);
    do_op("sra31", 32'h8000_0000, 32'h0000_001F, '0, 5'd8, 1'b0);
    check("sra31_flags_lit", FLAGS, 4'b1000);
    do_op("ill1f", 32'h1234_5678, 32'h9ABC_DEF0, '0, 5'h1F, 1'b1);
    do_op("rol0", 32'hA5A5_0001, 32'h0000_0000, '0, 5'd9, 1'b0);
    do_op("shl1", 32'h8000_0001, 32'h0000_0021, '0, 5'd6, 1'b0);
    do_op("add_ci", 32'h7FFF_FFFF, 32'h0000_0000, '0, 5'd0, 1'b1);

    // Backpressure: result held while a second op waits, then both handshakes on one edge.
    do_op("bp_first", 32'h0000_0010, 32'h0000_0020, '0, 5'd0, 1'b0);
    z1 = Z;
    OUT_READY = 1'b0;
    A = 32'h0000_0100; B = 32'h0000_0200; INST = 5'd0; CI = 1'b0; IN_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_inready", IN_READY, 0);
      @(posedge CLOCK); #1;
      check("bp_z_hold", Z, z1);
      check("bp_valid_hold", OUT_VALID, 1);
    end
    OUT_READY = 1'b1;
    #1;
    check("bp_inready_free", IN_READY, 1);
    @(posedge CLOCK); #1;
    IN_VALID = 1'b0;
    check("bp_second_z", Z, 32'h0000_0300);
    check("bp_second_valid", OUT_VALID, 1);

    // Reset pulse while a MADD is in flight.
    A = 32'h0000_0003; B = 32'h0000_0004; C = 32'h0000_0001; INST = 5'd11; IN_VALID = 1'b1;
    @(posedge CLOCK); #1;
    IN_VALID = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    check("rstmid_valid", OUT_VALID, 0);
    check("rstmid_inready", IN_READY, 0);
    @(posedge CLOCK); #2;
    RESET_N = 1'b1;
    @(posedge CLOCK); #1;
    check("rstmid_noresult", OUT_VALID, 0);
    check("rstmid_inready_rel", IN_READY, 1);
    @(posedge CLOCK); #1;
    check("rstmid_noresult2", OUT_VALID, 0);

    // Random operations, mostly legal opcodes.
    for (int i = 0; i < 60; i++) begin
      do_op("rand", $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            $urandom, 5'($urandom_range(0, 13)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) begin
      do_op("rand_ill", $urandom, $urandom, $urandom, 5'($urandom_range(12, 31)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/functional_unit_pipe.md
FUNCTIONAL_UNIT_PIPE -- requirements
Module: functional_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (min 8, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].
REQ-003 SHALL have port CLOCK input 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET_N input 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports A, B, C input WIDTH: operands.
REQ-006 SHALL have port INST input 5: opcode.
REQ-007 SHALL have port CI input 1: carry-in, used by ADD only.
REQ-008 SHALL have port IN_VALID input 1: operands/INST valid.
REQ-009 SHALL have port IN_READY output 1: block accepts the operation this cycle.
REQ-010 SHALL have port Z output WIDTH: registered result.
REQ-011 SHALL have port FLAGS output 4: registered {N,Z,C,V}, bit 3 = N.
REQ-012 SHALL have port ILLEGAL output 1: registered, result came from an undefined opcode.
REQ-013 SHALL have port OUT_VALID output 1: Z/FLAGS/ILLEGAL hold a result.
REQ-014 SHALL have port OUT_READY input 1: consumer takes the result this cycle.

Function
REQ-015 Accept SHALL occur on a rising edge with IN_VALID=1 and IN_READY=1; otherwise inputs are ignored.
REQ-016 IN_READY SHALL equal (state==IDLE) AND (OUT_VALID==0 OR OUT_READY==1), combinational.
REQ-017 Opcodes: 0 ADD A+B+CI; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL; 7 SHR logical; 8 SRA; 9 ROL; 10 PASS A; 11 MADD A*B+C (low WIDTH bits); 12-31 illegal.
REQ-018 Ops 0-10 SHALL have latency 1: result, flags and OUT_VALID=1 registered on the accepting edge.
REQ-019 MADD SHALL have latency 2: accepting edge registers low WIDTH bits of A*B and C, FSM IDLE->MUL; next edge with output free adds and loads result, MUL->IDLE.
REQ-020 In MUL with OUT_VALID=1 and OUT_READY=0, the FSM SHALL stay in MUL holding product and C until output frees.
REQ-021 OUT_VALID SHALL clear on an edge with OUT_READY=1 unless a new result loads on that same edge, in which case it stays 1 and the new result replaces the old.
REQ-022 Z/FLAGS/ILLEGAL SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 N = Z[WIDTH-1], Z flag = (Z==0) for all legal ops.
REQ-024 C: ADD carry-out; SUB no-borrow (1 iff A>=B unsigned); shifts/ROL last bit shifted/rotated out, 0 when amount is 0; MADD carry of product_low+C; else 0.
REQ-025 V: ADD/SUB signed two's-complement overflow; else 0.
REQ-026 Illegal opcode SHALL produce Z=0, FLAGS=0, ILLEGAL=1, latency 1; ILLEGAL=0 for legal ops.
REQ-027 Shift amount SHALL be B[SHW-1:0]; SRA fills with A[WIDTH-1].

Reset
REQ-028 RESET_N=0 SHALL immediately force state=IDLE, OUT_VALID=0, Z=0, FLAGS=0, ILLEGAL=0, clearing product and C registers.
REQ-029 Reset during MUL SHALL discard the pending MADD with no result produced.
REQ-030 IN_READY SHALL be 0 while RESET_N=0 and 1 on the first edge after release.

Configuration
REQ-031 Macro FUNCTIONAL_UNIT_MADD_EN defined: MADD implemented per REQ-019/REQ-024.
REQ-032 Macro FUNCTIONAL_UNIT_MADD_EN undefined: no multiplier or MUL state; opcode 11 treated as illegal per REQ-026 with latency 1.

Verification (WIDTH=32)
REQ-033 ADD A=FFFFFFFF B=00000001 CI=0 -> one cycle later Z=00000000, FLAGS=0110 (Z,C), OUT_VALID=1.
REQ-034 SUB A=80000000 B=00000001 -> Z=7FFFFFFF, FLAGS=0011 (C,V).
REQ-035 MADD A=00010000 B=00010000 C=00000005 -> two cycles later Z=00000005, FLAGS=0000, IN_READY=0 during MUL; with macro undefined -> ILLEGAL=1, Z=0 after one cycle.
REQ-036 OUT_READY=0 held 3 cycles after an ADD result, second op offered -> IN_READY=0, Z unchanged; OUT_READY=1 -> second op accepted, new result next edge with OUT_VALID continuous.
REQ-037 SRA A=80000000 B=0000001F -> Z=FFFFFFFF, FLAGS=1000; INST=1F -> Z=0, FLAGS=0, ILLEGAL=1.
REQ-038 RESET_N pulsed low mid-MADD -> OUT_VALID=0 immediately, no result after release, IN_READY=1.
